// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store engine for the Mem stage.
// Accepts one pipeline request at a time and checks its alignment. Aligned
// requests run on an SRAM-like bus (req/addr_ok/data_ok). A misaligned request
// never reaches the bus and is reported as an exception instead.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*             pipeline request (valid/ready, we, size, signed, addr, wdata)
//   flush             cancel the current/pending request
//   bus_*             SRAM-like bus master (req, wr, addr, be, wdata, addr_ok,
//                     data_ok, rdata)
//   resp_*            one-cycle response pulse carrying load data and exceptions
//   busy              engine not idle
module mem_access_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  flush,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_load_exc,
  output logic                  resp_store_exc,
  output logic [ADDR_W-1:0]     resp_badaddr,
  output logic                  busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_EXC} state_t;

  state_t state, state_d;
  logic   drop, drop_d;

  // Request fields captured on accept
  logic              lat_we, lat_we_d;
  logic [1:0]        lat_size, lat_size_d;
  logic              lat_signed, lat_signed_d;
  logic [OFF_W-1:0]  lat_off, lat_off_d;
  logic [ADDR_W-1:0] lat_addr, lat_addr_d;

  // Next values of the registered outputs
  logic              bus_req_d, bus_wr_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [BE_W-1:0]   bus_be_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic              resp_valid_d, resp_load_exc_d, resp_store_exc_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic [ADDR_W-1:0] resp_badaddr_d;

  logic              accept;
  logic              misaligned;
  logic [2:0]        addr_lo;
  logic [BE_W-1:0]   be_mask;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] keep_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;

  assign req_ready = (state == S_IDLE) & ~flush;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;
  assign addr_lo   = req_addr[2:0];

  // Alignment check, lane mask and store-data replication for the incoming request
  always_comb begin
    misaligned = 1'b0;
    be_mask    = BE_W'(1);
    wdata_rep  = req_wdata;
    case (req_size)
      2'd0: begin
        be_mask   = BE_W'(1);
        wdata_rep = {BE_W{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = addr_lo[0];
        be_mask    = BE_W'(4'h3);
        wdata_rep  = {(DATA_W/16){req_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = |addr_lo[1:0];
        be_mask    = BE_W'(4'hF);
        wdata_rep  = {(DATA_W/32){req_wdata[31:0]}};
      end
      default: begin
        // A dword can never be carried on a 32-bit bus
        misaligned = (DATA_W == 32) ? 1'b1 : (|addr_lo);
        be_mask    = BE_W'(8'hFF);
        wdata_rep  = req_wdata;
      end
    endcase
  end

  // Load data: bring the addressed lanes down to bit 0, then extend
  always_comb begin
    rd_shift  = bus_rdata >> {lat_off, 3'b000};
    keep_mask = '1;
    sign_bit  = rd_shift[DATA_W-1];
    case (lat_size)
      2'd0: begin
        keep_mask = DATA_W'(8'hFF);
        sign_bit  = rd_shift[7];
      end
      2'd1: begin
        keep_mask = DATA_W'(16'hFFFF);
        sign_bit  = rd_shift[15];
      end
      2'd2: begin
        keep_mask = DATA_W'(32'hFFFF_FFFF);
        sign_bit  = rd_shift[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = rd_shift[DATA_W-1];
      end
    endcase
    load_ext = (rd_shift & keep_mask) | ((lat_signed & sign_bit) ? ~keep_mask : '0);
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_d          = state;
    drop_d           = drop;
    lat_we_d         = lat_we;
    lat_size_d       = lat_size;
    lat_signed_d     = lat_signed;
    lat_off_d        = lat_off;
    lat_addr_d       = lat_addr;
    bus_req_d        = bus_req;
    bus_wr_d         = bus_wr;
    bus_addr_d       = bus_addr;
    bus_be_d         = bus_be;
    bus_wdata_d      = bus_wdata;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = '0;
    resp_load_exc_d  = 1'b0;
    resp_store_exc_d = 1'b0;
    resp_badaddr_d   = '0;

    case (state)
      S_IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          lat_we_d     = req_we;
          lat_size_d   = req_size;
          lat_signed_d = req_signed;
          lat_off_d    = req_addr[OFF_W-1:0];
          lat_addr_d   = req_addr;
          if (misaligned) begin
            state_d  = S_EXC;
            bus_be_d = '0;
          end else begin
            state_d     = S_ADDR;
            bus_req_d   = 1'b1;
            bus_wr_d    = req_we;
            bus_addr_d  = req_addr & ~(ADDR_W'(BE_W - 1));
            bus_be_d    = be_mask << req_addr[OFF_W-1:0];
            bus_wdata_d = wdata_rep;
          end
        end
      end
      S_ADDR: begin
        // A flushed request stays on the bus until the slave takes it
        if (flush) drop_d = 1'b1;
        if (bus_addr_ok) begin
          state_d   = S_DATA;
          bus_req_d = 1'b0;
          bus_wr_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (flush) drop_d = 1'b1;
        if (bus_data_ok) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (!drop && !flush) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = lat_we ? '0 : load_ext;
          end
        end
      end
      S_EXC: begin
        // Exception pulse is issued on leaving EXC so a flush here can cancel it
        state_d = S_IDLE;
        drop_d  = 1'b0;
        if (!flush) begin
          resp_valid_d     = 1'b1;
          resp_load_exc_d  = ~lat_we;
          resp_store_exc_d = lat_we;
          resp_badaddr_d   = lat_addr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      drop           <= 1'b0;
      lat_we         <= 1'b0;
      lat_size       <= 2'd0;
      lat_signed     <= 1'b0;
      lat_off        <= '0;
      lat_addr       <= '0;
      bus_req        <= 1'b0;
      bus_wr         <= 1'b0;
      bus_addr       <= '0;
      bus_be         <= '0;
      bus_wdata      <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_load_exc  <= 1'b0;
      resp_store_exc <= 1'b0;
      resp_badaddr   <= '0;
    end else begin
      state          <= state_d;
      drop           <= drop_d;
      lat_we         <= lat_we_d;
      lat_size       <= lat_size_d;
      lat_signed     <= lat_signed_d;
      lat_off        <= lat_off_d;
      lat_addr       <= lat_addr_d;
      bus_req        <= bus_req_d;
      bus_wr         <= bus_wr_d;
      bus_addr       <= bus_addr_d;
      bus_be         <= bus_be_d;
      bus_wdata      <= bus_wdata_d;
      resp_valid     <= resp_valid_d;
      resp_rdata     <= resp_rdata_d;
      resp_load_exc  <= resp_load_exc_d;
      resp_store_exc <= resp_store_exc_d;
      resp_badaddr   <= resp_badaddr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: one 32-bit and one 64-bit instance
// share the bus handshake inputs; each has its own req_valid.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid32, req_valid64;
  logic        req_we, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  logic        a_rdy, a_bus_req, a_bus_wr, a_resp_valid, a_lexc, a_sexc, a_busy;
  logic [31:0] a_bus_addr, a_bus_wdata, a_resp_rdata, a_badaddr;
  logic [3:0]  a_bus_be;

  logic        b_rdy, b_bus_req, b_bus_wr, b_resp_valid, b_lexc, b_sexc, b_busy;
  logic [31:0] b_bus_addr, b_badaddr;
  logic [63:0] b_bus_wdata, b_resp_rdata;
  logic [7:0]  b_bus_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(a_rdy), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .flush(flush),
    .bus_req(a_bus_req), .bus_wr(a_bus_wr), .bus_addr(a_bus_addr),
    .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata[31:0]),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_load_exc(a_lexc), .resp_store_exc(a_sexc),
    .resp_badaddr(a_badaddr), .busy(a_busy)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(b_rdy), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush),
    .bus_req(b_bus_req), .bus_wr(b_bus_wr), .bus_addr(b_bus_addr),
    .bus_be(b_bus_be), .bus_wdata(b_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_load_exc(b_lexc), .resp_store_exc(b_sexc),
    .resp_badaddr(b_badaddr), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wd);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  initial begin
    rst = 1'b1; req_valid32 = 1'b0; req_valid64 = 1'b0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    set_req(1'b0, 2'd0, 1'b0, 32'h0, 64'h0);
    tick(); tick();
    chk("rst_ready", 64'(a_rdy), 64'd1);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_bus_req", 64'(a_bus_req), 64'd0);
    chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_bus_be", 64'(a_bus_be), 64'd0);
    rst = 1'b0;
    tick();

    // 1: signed byte load at 0x1003, addr_ok/data_ok at first chance
    set_req(1'b0, 2'd0, 1'b1, 32'h1003, 64'h0);
    bus_rdata = 64'h0000_0000_80FF_1234;
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    chk("t1_bus_req", 64'(a_bus_req), 64'd1);
    chk("t1_bus_be", 64'(a_bus_be), 64'h8);
    chk("t1_bus_addr", 64'(a_bus_addr), 64'h1000);
    chk("t1_bus_wr", 64'(a_bus_wr), 64'd0);
    chk("t1_ready_busy", 64'(a_rdy), 64'd0);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    chk("t1_req_drop", 64'(a_bus_req), 64'd0);
    chk("t1_no_early_resp", 64'(a_resp_valid), 64'd0);
    bus_data_ok = 1'b1;
    tick();
    bus_data_ok = 1'b0;
    chk("t1_resp_valid", 64'(a_resp_valid), 64'd1);
    chk("t1_resp_rdata", 64'(a_resp_rdata), 64'hFFFF_FF80);
    chk("t1_idle", 64'(a_busy), 64'd0);
    tick();
    chk("t1_pulse_end", 64'(a_resp_valid), 64'd0);

    // 2: half store at 0x2002
    set_req(1'b1, 2'd1, 1'b0, 32'h2002, 64'h0000_ABCD);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    chk("t2_bus_wr", 64'(a_bus_wr), 64'd1);
    chk("t2_bus_be", 64'(a_bus_be), 64'hC);
    chk("t2_bus_wdata", 64'(a_bus_wdata), 64'hABCD_ABCD);
    chk("t2_bus_addr", 64'(a_bus_addr), 64'h2000);
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; tick(); bus_data_ok = 1'b0;
    chk("t2_resp_valid", 64'(a_resp_valid), 64'd1);
    chk("t2_resp_rdata", 64'(a_resp_rdata), 64'd0);
    tick();

    // 3: misaligned word load, then misaligned half store
    set_req(1'b0, 2'd2, 1'b0, 32'h3002, 64'h0);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    chk("t3_no_bus_req", 64'(a_bus_req), 64'd0);
    chk("t3_exc_busy", 64'(a_busy), 64'd1);
    chk("t3_exc_be", 64'(a_bus_be), 64'd0);
    tick();
    chk("t3_resp_valid", 64'(a_resp_valid), 64'd1);
    chk("t3_load_exc", 64'(a_lexc), 64'd1);
    chk("t3_store_exc0", 64'(a_sexc), 64'd0);
    chk("t3_badaddr", 64'(a_badaddr), 64'h3002);
    chk("t3_rdata0", 64'(a_resp_rdata), 64'd0);
    set_req(1'b1, 2'd1, 1'b0, 32'h3001, 64'h1234);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    chk("t3s_no_bus_req", 64'(a_bus_req), 64'd0);
    tick();
    chk("t3s_resp_valid", 64'(a_resp_valid), 64'd1);
    chk("t3s_store_exc", 64'(a_sexc), 64'd1);
    chk("t3s_load_exc0", 64'(a_lexc), 64'd0);
    chk("t3s_badaddr", 64'(a_badaddr), 64'h3001);
    tick();

    // 4: 64-bit bus: dword unsigned at 0x8, half unsigned at 0xE, word signed at 0x4
    set_req(1'b0, 2'd3, 1'b0, 32'h8, 64'h0);
    bus_rdata = 64'h1122_3344_5566_7788;
    req_valid64 = 1'b1;
    tick();
    req_valid64 = 1'b0;
    chk("t4a_bus_be", 64'(b_bus_be), 64'hFF);
    chk("t4a_bus_addr", 64'(b_bus_addr), 64'h8);
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; tick(); bus_data_ok = 1'b0;
    chk("t4a_resp_valid", 64'(b_resp_valid), 64'd1);
    chk("t4a_resp_rdata", b_resp_rdata, 64'h1122_3344_5566_7788);
    set_req(1'b0, 2'd1, 1'b0, 32'hE, 64'h0);
    bus_rdata = 64'hBEEF_0000_0000_0000;
    req_valid64 = 1'b1;
    tick();
    req_valid64 = 1'b0;
    chk("t4b_bus_be", 64'(b_bus_be), 64'hC0);
    chk("t4b_bus_addr", 64'(b_bus_addr), 64'h8);
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; tick(); bus_data_ok = 1'b0;
    chk("t4b_resp_rdata", b_resp_rdata, 64'h0000_0000_0000_BEEF);
    set_req(1'b0, 2'd2, 1'b1, 32'h4, 64'h0);
    bus_rdata = 64'h8000_0001_0000_0000;
    req_valid64 = 1'b1;
    tick();
    req_valid64 = 1'b0;
    chk("t4c_bus_be", 64'(b_bus_be), 64'hF0);
    chk("t4c_bus_addr", 64'(b_bus_addr), 64'h0);
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; tick(); bus_data_ok = 1'b0;
    chk("t4c_resp_rdata", b_resp_rdata, 64'hFFFF_FFFF_8000_0001);
    tick();

    // 5: flush in ADDR, addr_ok held off for 4 cycles
    set_req(1'b0, 2'd2, 1'b0, 32'h4000, 64'h0);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_bus_req_held", 64'(a_bus_req), 64'd1);
      flush = (i == 0);
      tick();
    end
    flush = 1'b0;
    chk("t5_still_addr", 64'(a_bus_req), 64'd1);
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    chk("t5_in_data", 64'(a_busy), 64'd1);
    bus_data_ok = 1'b1; tick(); bus_data_ok = 1'b0;
    chk("t5_resp_suppressed", 64'(a_resp_valid), 64'd0);
    chk("t5_ready_back", 64'(a_rdy), 64'd1);
    // Flush with req_valid in IDLE blocks the accept
    req_valid32 = 1'b1; flush = 1'b1;
    #1;
    chk("t5_ready_flush", 64'(a_rdy), 64'd0);
    tick();
    req_valid32 = 1'b0; flush = 1'b0;
    chk("t5_not_accepted", 64'(a_busy), 64'd0);
    chk("t5_no_bus_req", 64'(a_bus_req), 64'd0);

    // Flush in EXC cancels the exception response
    set_req(1'b0, 2'd1, 1'b0, 32'h5001, 64'h0);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5e_exc_suppressed", 64'(a_resp_valid), 64'd0);
    chk("t5e_no_load_exc", 64'(a_lexc), 64'd0);
    chk("t5e_idle", 64'(a_busy), 64'd0);

    // data_ok together with flush in DATA suppresses the response
    set_req(1'b0, 2'd0, 1'b0, 32'h6000, 64'h0);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; flush = 1'b1;
    tick();
    bus_data_ok = 1'b0; flush = 1'b0;
    chk("t5d_resp_suppressed", 64'(a_resp_valid), 64'd0);
    chk("t5d_idle", 64'(a_busy), 64'd0);
    tick();

    // 6: reset while in DATA, then a late data_ok
    set_req(1'b0, 2'd2, 1'b0, 32'h7000, 64'h0);
    req_valid32 = 1'b1;
    tick();
    req_valid32 = 1'b0;
    bus_addr_ok = 1'b1; tick(); bus_addr_ok = 1'b0;
    chk("t6_in_data", 64'(a_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_idle", 64'(a_busy), 64'd0);
    bus_data_ok = 1'b1;
    tick();
    bus_data_ok = 1'b0;
    chk("t6_late_data_ok", 64'(a_resp_valid), 64'd0);
    chk("t6_busy", 64'(a_busy), 64'd0);
    tick();
    chk("t6_no_resp", 64'(a_resp_valid), 64'd0);
    chk("t6_ready", 64'(a_rdy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
